// File: rtl/ads1256_scan_sequencer_pkg.sv
// ADS1256 scan sequencer shared definitions:
// command opcodes, scan states and the command word builder.
package ads1256_scan_sequencer_pkg;

    localparam logic [7:0] OP_WAKEUP   = 8'h00;
    localparam logic [7:0] OP_RDATA    = 8'h01;
    localparam logic [7:0] OP_SYNC     = 8'hFC;
    localparam logic [7:0] OP_WREG_MUX = 8'h51;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_MUX,
        S_SYNC,
        S_WAKEUP,
        S_WAIT_DRDY,
        S_RDATA,
        S_EMIT,
        S_NEXT
    } scan_state_e;

    // WREG MUX writes one register (count byte 0) with the channel's mux byte
    function automatic logic [23:0] cmd_of(scan_state_e s, logic [7:0] mux);
        logic [23:0] c;
        c = 24'h0;
        case (s)
            S_SET_MUX: c = {OP_WREG_MUX, 8'h00, mux};
            S_SYNC:    c = {OP_SYNC, 16'h0000};
            S_WAKEUP:  c = {OP_WAKEUP, 16'h0000};
            S_RDATA:   c = {OP_RDATA, 16'h0000};
            default:   c = 24'h0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ads1256_scan_sequencer_if.sv
// Command/response link between the scan sequencer and the SPI engine.
interface ads1256_scan_sequencer_if;
    import ads1256_scan_sequencer_pkg::*;

    logic        transaction_start_o;
    logic [23:0] command_o;
    logic        transaction_done_i;
    logic [23:0] transaction_data_i;

    modport master (
        output transaction_start_o,
        output command_o,
        input  transaction_done_i,
        input  transaction_data_i
    );

    modport slave (
        input  transaction_start_o,
        input  command_o,
        output transaction_done_i,
        output transaction_data_i
    );

endinterface

// File: rtl/ads1256_sample_accumulator.sv
// Per-channel conversion accumulator; result is the floor-divided mean
// of 2^AVG_LOG2 sign-extended 24-bit words.
module ads1256_sample_accumulator
    import ads1256_scan_sequencer_pkg::*;
#(
    parameter int AVG_LOG2 = 0
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        clear,
    input  logic        add,
    input  logic [23:0] word,
    output logic [23:0] result
);

    localparam int ACC_W = 24 + AVG_LOG2;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] word_ext;

    assign word_ext = ACC_W'($signed(word));

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (add) begin
            acc <= acc + word_ext;
        end
    end

    // arithmetic shift rounds toward minus infinity
    assign result = 24'(acc >>> AVG_LOG2);

endmodule

// File: rtl/ads1256_scan_sequencer.sv
// ADS1256 multi-channel scan sequencer: mux setup, sync/wakeup,
// DRDY-paced RDATA reads, averaging and sample hand-off.
module ads1256_scan_sequencer
    import ads1256_scan_sequencer_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int AVG_LOG2     = 0,
    parameter int DRDY_TIMEOUT = 2_000_000
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic                      continuous_i,
    input  logic                      stop_i,
    input  logic [8*NUM_CHANNELS-1:0] mux_cfg_i,
    input  logic                      drdy_ni,
    ads1256_scan_sequencer_if.master  spi,
    output logic                      sample_valid_o,
    input  logic                      sample_ready_i,
    output logic [2:0]                sample_channel_o,
    output logic [23:0]               sample_data_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o
);

    localparam int NCONV = 1 << AVG_LOG2;

    scan_state_e               state;
    logic [2:0]                chan;
    logic [2:0]                chan_nxt;
    logic                      cont_q;
    logic                      stop_q;
    logic                      pending;
    logic [8*NUM_CHANNELS-1:0] cfg_q;
    logic [31:0]               wait_cnt;
    logic [4:0]                conv_cnt;
    logic                      xfer_done;
    logic                      last_chan;
    logic [7:0]                mux_nxt;
    logic [23:0]               acc_result;

    assign xfer_done = pending && spi.transaction_done_i;
    assign last_chan = (chan == 3'(NUM_CHANNELS - 1));
    assign chan_nxt  = last_chan ? 3'd0 : chan + 3'd1;
    assign mux_nxt   = cfg_q[{chan_nxt, 3'b000} +: 8];
    assign busy_o    = (state != S_IDLE);

    ads1256_sample_accumulator #(
        .AVG_LOG2(AVG_LOG2)
    ) u_acc (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .clear  (state == S_IDLE || state == S_NEXT),
        .add    (state == S_RDATA && xfer_done),
        .word   (spi.transaction_data_i),
        .result (acc_result)
    );

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state                   <= S_IDLE;
            chan                    <= '0;
            cont_q                  <= 1'b0;
            stop_q                  <= 1'b0;
            pending                 <= 1'b0;
            cfg_q                   <= '0;
            wait_cnt                <= '0;
            conv_cnt                <= '0;
            spi.transaction_start_o <= 1'b0;
            spi.command_o           <= '0;
            sample_valid_o          <= 1'b0;
            sample_channel_o        <= '0;
            sample_data_o           <= '0;
            done_o                  <= 1'b0;
            error_o                 <= 1'b0;
        end else begin
            spi.transaction_start_o <= 1'b0;
            done_o                  <= 1'b0;
            if (stop_i && state != S_IDLE) stop_q <= 1'b1;
            if (xfer_done) begin
                pending       <= 1'b0;
                spi.command_o <= '0;
            end
            // each command state is entered together with its request pulse
            unique case (state)
                S_IDLE: if (start_i) begin
                    cfg_q                   <= mux_cfg_i;
                    cont_q                  <= continuous_i;
                    error_o                 <= 1'b0;
                    chan                    <= '0;
                    stop_q                  <= 1'b0;
                    state                   <= S_SET_MUX;
                    spi.transaction_start_o <= 1'b1;
                    spi.command_o           <= cmd_of(S_SET_MUX, mux_cfg_i[7:0]);
                    pending                 <= 1'b1;
                end
                S_SET_MUX: if (xfer_done) begin
                    state                   <= S_SYNC;
                    spi.transaction_start_o <= 1'b1;
                    spi.command_o           <= cmd_of(S_SYNC, 8'h00);
                    pending                 <= 1'b1;
                end
                S_SYNC: if (xfer_done) begin
                    state                   <= S_WAKEUP;
                    spi.transaction_start_o <= 1'b1;
                    spi.command_o           <= cmd_of(S_WAKEUP, 8'h00);
                    pending                 <= 1'b1;
                end
                S_WAKEUP: if (xfer_done) begin
                    state    <= S_WAIT_DRDY;
                    wait_cnt <= '0;
                    conv_cnt <= '0;
                end
                S_WAIT_DRDY: begin
                    if (!drdy_ni) begin
                        state                   <= S_RDATA;
                        spi.transaction_start_o <= 1'b1;
                        spi.command_o           <= cmd_of(S_RDATA, 8'h00);
                        pending                 <= 1'b1;
                    end else if (wait_cnt == 32'(DRDY_TIMEOUT - 1)) begin
                        error_o <= 1'b1;
                        done_o  <= 1'b1;
                        stop_q  <= 1'b0;
                        chan    <= '0;
                        state   <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_RDATA: if (xfer_done) begin
                    conv_cnt <= conv_cnt + 5'd1;
                    wait_cnt <= '0;
                    state    <= (conv_cnt == 5'(NCONV - 1)) ? S_EMIT : S_WAIT_DRDY;
                end
                // first cycle loads the sample, then hold until accepted
                S_EMIT: begin
                    if (!sample_valid_o) begin
                        sample_valid_o   <= 1'b1;
                        sample_channel_o <= chan;
                        sample_data_o    <= acc_result;
                    end else if (sample_ready_i) begin
                        sample_valid_o <= 1'b0;
                        state          <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (stop_q || stop_i || (last_chan && !cont_q)) begin
                        done_o <= 1'b1;
                        stop_q <= 1'b0;
                        chan   <= '0;
                        state  <= S_IDLE;
                    end else begin
                        chan                    <= chan_nxt;
                        state                   <= S_SET_MUX;
                        spi.transaction_start_o <= 1'b1;
                        spi.command_o           <= cmd_of(S_SET_MUX, mux_nxt);
                        pending                 <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ads1256_scan_sequencer.md
ADS1256_SCAN_SEQUENCER -- requirements
Module: ads1256_scan_sequencer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 8, number of mux entries scanned (1..8).
REQ-002 SHALL have parameter AVG_LOG2, default 0, log2 of conversions averaged per channel (0..4).
REQ-003 SHALL have parameter DRDY_TIMEOUT, default 2_000_000, max clock cycles waited for DRDY low.
REQ-004 SHALL have ports:
- clock_i  in  1  system clock; one clock domain only.
- reset_i  in  1  asynchronous, active-low reset.
- start_i  in  1  begin scan when idle.
- continuous_i  in  1  sampled at start: 1 = repeat scans until stop.
- stop_i  in  1  request stop at end of current channel.
- mux_cfg_i  in  8*NUM_CHANNELS  MUX register byte per channel; entry k at bits [8k+7:8k].
- drdy_ni  in  1  ADS1256 DRDY, active-low, pre-synchronised.
- transaction_start_o  out  1  one-cycle request to SPI engine.
- command_o  out  24  command bytes, MSB first, valid while transaction pending.
- transaction_done_i  in  1  one-cycle SPI completion pulse.
- transaction_data_i  in  24  conversion word returned by RDATA, valid with done.
- sample_valid_o  out  1  averaged sample available.
- sample_ready_i  in  1  consumer accepts sample.
- sample_channel_o  out  3  channel index of sample.
- sample_data_o  out  24  averaged two's-complement result.
- busy_o  out  1  not IDLE.
- done_o  out  1  one-cycle pulse on return to IDLE.
- error_o  out  1  sticky DRDY-timeout flag; cleared by next accepted start.

Function
REQ-005 SHALL latch mux_cfg_i and continuous_i on start_i in IDLE; start_i while busy SHALL be ignored.
REQ-006 SHALL sequence states IDLE -> SET_MUX -> SYNC -> WAKEUP -> WAIT_DRDY -> RDATA -> (WAIT_DRDY until 2^AVG_LOG2 conversions) -> EMIT -> NEXT.
REQ-007 SHALL issue commands: SET_MUX 0x51_00_<mux byte>, SYNC 0xFC_00_00, WAKEUP 0x00_00_00, RDATA 0x01_00_00.
REQ-008 SHALL assert transaction_start_o for exactly one cycle on state entry, hold command_o stable until transaction_done_i, advance the cycle after done.
REQ-009 SHALL ignore transaction_done_i when no transaction is pending.
REQ-010 SHALL in WAIT_DRDY advance on first cycle drdy_ni = 0; after DRDY_TIMEOUT cycles set error_o, pulse done_o, return IDLE.
REQ-011 SHALL accumulate sign-extended words in a (24+AVG_LOG2)-bit accumulator cleared per channel; result = arithmetic right shift by AVG_LOG2, truncating toward minus infinity.
REQ-012 SHALL in EMIT hold sample_valid_o, channel, data stable until sample_ready_i; transfer on valid && ready; no further command issued while stalled.
REQ-013 SHALL in NEXT increment channel index; after NUM_CHANNELS-1 wrap to 0 if continuous, else pulse done_o and go IDLE.
REQ-014 SHALL register stop_i as pending; pending stop SHALL end the scan at NEXT regardless of channel index or continuous mode.
REQ-015 SHALL treat stop_i coincident with the final NEXT of a single scan identically to normal completion (one done_o pulse).
REQ-016 SHALL issue no command and no sample in IDLE.

Reset
REQ-017 SHALL on reset_i low force IDLE, channel 0, accumulator 0, stop-pending 0, all outputs 0, including mid-transaction; an outstanding transaction_done_i after reset SHALL be ignored.

Structure
REQ-018 SHALL place command opcodes (WAKEUP, RDATA, SYNC, WREG MUX) and the scan state enum in the shared ADS1256 package.
REQ-019 SHALL implement averaging in sub-module ads1256_sample_accumulator (clear, add, result).

Verification
REQ-020 NUM_CHANNELS=2, AVG_LOG2=0, mux 0x01/0x23, single scan, DRDY low 10 cycles after WAKEUP, data 0x000100/0xFFFF00 -> commands 0x510001, 0xFC0000, 0x000000, 0x010000, then 0x510023...; samples (0,0x000100),(1,0xFFFF00); one done_o.
REQ-021 AVG_LOG2=2, words 4,4,5,-1 -> sample_data_o = 0x000003; words -1,-1,-1,-2 -> 0xFFFFFE.
REQ-022 sample_ready_i low 50 cycles -> valid/data/channel held, no transaction_start_o until ready.
REQ-023 continuous, NUM_CHANNELS=3, stop_i pulse during channel 1 RDATA -> channel 1 sample emitted, done_o, no channel 2 SET_MUX.
REQ-024 DRDY_TIMEOUT=100, drdy_ni held high -> error_o=1 and done_o at cycle 100 of WAIT_DRDY; next start clears error_o.
REQ-025 reset_i low during SYNC pending, late transaction_done_i after release -> IDLE, all outputs 0, no state change.
